// File: rtl/ialu_shadow_checker.sv
// ialu_shadow_checker
// Golden-model checker for I-type ALU instructions. It runs beside the core.
// Each accepted OP-IMM instruction is executed against a shadow register
// file. The expected writeback {rd, result} is delayed by LATENCY cycles and
// then compared with the core's writeback port.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   instr_valid, instr    instruction stream, one word per cycle
//   rf_init_*             seed write into the shadow register file
//   wb_valid/wb_rd/wb_data  core register-file write port under test
//   exp_valid/exp_rd/exp_data  expected writeback due this cycle (registered)
//   err_pulse             combinational error strobe for the current cycle
//   mismatch              sticky error flag
//   retire_cnt, err_cnt   saturating counts of matched writebacks / errors
module ialu_shadow_checker #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int LATENCY   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  input  logic                 rf_init_we,
  input  logic [4:0]           rf_init_addr,
  input  logic [WORD_SIZE-1:0] rf_init_data,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 exp_valid,
  output logic [4:0]           exp_rd,
  output logic [WORD_SIZE-1:0] exp_data,
  output logic                 err_pulse,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI  = 3'd0;
  localparam logic [2:0] F3_SLLI  = 3'd1;
  localparam logic [2:0] F3_SLTI  = 3'd2;
  localparam logic [2:0] F3_SLTIU = 3'd3;
  localparam logic [2:0] F3_XORI  = 3'd4;
  localparam logic [2:0] F3_SRXI  = 3'd5;
  localparam logic [2:0] F3_ORI   = 3'd6;
  localparam logic [2:0] F3_ANDI  = 3'd7;

  logic [6:0]           opcode;
  logic [4:0]           rd;
  logic [2:0]           funct3;
  logic [4:0]           rs1_idx;
  logic [4:0]           shamt;
  logic [WORD_SIZE-1:0] imm;
  logic [WORD_SIZE-1:0] rs1_val;
  logic [WORD_SIZE-1:0] alu_result;
  logic                 accept;
  logic                 execute;
  logic                 push;

  logic [WORD_SIZE-1:0] shadow_rf [NUM_REGS];

  logic                 pipe_valid [LATENCY];
  logic [4:0]           pipe_rd    [LATENCY];
  logic [WORD_SIZE-1:0] pipe_data  [LATENCY];

  logic fields_equal;
  logic retire_hit;
  logic err_hit;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign shamt   = instr[24:20];
  assign imm     = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};

  // A seed write takes priority; an instruction in the same cycle is dropped.
  assign accept  = instr_valid & ~rf_init_we;
  assign execute = accept && (opcode == OPCODE_OP_IMM);
  assign push    = execute && (rd != 5'd0);

  assign rs1_val = (rs1_idx == 5'd0) ? '0 : shadow_rf[rs1_idx];

  // Architectural result of the current instruction.
  always_comb begin
    alu_result = '0;
    case (funct3)
      F3_ADDI:  alu_result = rs1_val + imm;
      F3_SLTI:  alu_result = {{(WORD_SIZE-1){1'b0}}, ($signed(rs1_val) < $signed(imm))};
      F3_SLTIU: alu_result = {{(WORD_SIZE-1){1'b0}}, (rs1_val < imm)};
      F3_XORI:  alu_result = rs1_val ^ imm;
      F3_ORI:   alu_result = rs1_val | imm;
      F3_ANDI:  alu_result = rs1_val & imm;
      F3_SLLI:  alu_result = rs1_val << shamt;
      F3_SRXI:  alu_result = instr[30] ? WORD_SIZE'($signed(rs1_val) >>> shamt)
                                       : (rs1_val >> shamt);
    endcase
  end

  // Shadow register file. Reset does not clear it, so contents survive a
  // mid-stream reset. It is updated at the accept edge, which lets the next
  // instruction see the result without forwarding.
  always_ff @(posedge clk) begin
    if (rf_init_we) begin
      if (rf_init_addr != 5'd0) shadow_rf[rf_init_addr] <= rf_init_data;
    end else if (push) begin
      shadow_rf[rd] <= alu_result;
    end
  end

  // Delay line for expected writebacks. Its last stage drives exp_*.
  // Empty slots carry zeros, so exp_rd/exp_data read 0 whenever exp_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rd[i]    <= '0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= push;
      pipe_rd[0]    <= push ? rd : 5'd0;
      pipe_data[0]  <= push ? alu_result : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rd[i]    <= pipe_rd[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign exp_valid = pipe_valid[LATENCY-1];
  assign exp_rd    = pipe_rd[LATENCY-1];
  assign exp_data  = pipe_data[LATENCY-1];

  // The error is raised when a due entry is missing or differs from the core
  // write, or when the core writes a non-zero register with nothing due.
  assign fields_equal = (wb_rd == exp_rd) && (wb_data == exp_data);
  assign retire_hit   = exp_valid & wb_valid & fields_equal;
  assign err_hit      = exp_valid ? (~wb_valid | ~fields_equal)
                                  : (wb_valid & (wb_rd != 5'd0));
  assign err_pulse    = err_hit & ~reset;

  // Sticky flag and saturating counters, updated one edge after the compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch   <= 1'b0;
      retire_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      if (retire_hit && (retire_cnt != {CNT_W{1'b1}}))
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (err_hit) begin
        mismatch <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}})
          err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ialu_shadow_checker.sv
// Self-checking bench for ialu_shadow_checker. A behavioural model keeps an
// architectural register array and a schedule of expected writebacks, indexed
// by cycle number. Directed scenarios are followed by a randomized stream.
module tb_ialu_shadow_checker;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        rf_init_we = 1'b0;
  logic [4:0]  rf_init_addr = '0;
  logic [31:0] rf_init_data = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        exp_valid;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        err_pulse;
  logic        mismatch;
  logic [15:0] retire_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;

  ialu_shadow_checker #(
    .WORD_SIZE(32), .NUM_REGS(32), .LATENCY(LAT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr),
    .rf_init_we(rf_init_we), .rf_init_addr(rf_init_addr), .rf_init_data(rf_init_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exp_valid(exp_valid), .exp_rd(exp_rd), .exp_data(exp_data),
    .err_pulse(err_pulse), .mismatch(mismatch),
    .retire_cnt(retire_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] shadow [32];
  logic        due_v    [64];
  logic [4:0]  due_rd   [64];
  logic [31:0] due_data [64];
  int          cyc = 0;
  int unsigned m_retire, m_err;
  logic        m_mismatch;

  // Predictions and observations captured in the same cycle
  logic        p_ev, p_err, p_mismatch;
  logic [4:0]  p_erd;
  logic [31:0] p_edata;
  int unsigned p_retire, p_errcnt;
  logic        o_ev, o_err, o_mismatch;
  logic [4:0]  o_erd;
  logic [31:0] o_edata;
  logic [15:0] o_retire, o_errcnt;

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] ref_exec(input logic [31:0] ins, input logic [31:0] a);
    logic [31:0] imm;
    int sh;
    logic [31:0] r;
    imm = {{20{ins[31]}}, ins[31:20]};
    sh = int'(ins[24:20]);
    r = 32'd0;
    case (ins[14:12])
      3'd0: r = a + imm;
      3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      3'd3: r = (a < imm) ? 32'd1 : 32'd0;
      3'd4: r = a ^ imm;
      3'd6: r = a | imm;
      3'd7: r = a & imm;
      3'd1: r = a << sh;
      default: begin
        r = a >> sh;
        if (ins[30] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      due_v[i] = 1'b0; due_rd[i] = '0; due_data[i] = '0;
    end
    m_retire = 0; m_err = 0; m_mismatch = 1'b0;
  endtask

  // One clock cycle. mode 0: wb mirrors the model's due entry; 1: due entry with
  // data bit 0 flipped; 2: no wb at all; 3: manual wb values.
  task automatic drive(input logic i_v, input logic [31:0] i_ins,
                       input logic s_we, input logic [4:0] s_a, input logic [31:0] s_d,
                       input int mode, input logic m_wv, input logic [4:0] m_rd,
                       input logic [31:0] m_data);
    int slot, tgt;
    logic [31:0] res, a;
    logic dwv;
    logic [4:0] drd;
    logic [31:0] ddata;
    @(negedge clk);
    slot = cyc % 64;
    p_ev = due_v[slot]; p_erd = due_rd[slot]; p_edata = due_data[slot];
    case (mode)
      0: begin dwv = p_ev; drd = p_erd; ddata = p_edata; end
      1: begin dwv = p_ev; drd = p_erd; ddata = p_edata ^ 32'd1; end
      2: begin dwv = 1'b0; drd = '0; ddata = '0; end
      default: begin dwv = m_wv; drd = m_rd; ddata = m_data; end
    endcase
    instr_valid = i_v; instr = i_ins;
    rf_init_we = s_we; rf_init_addr = s_a; rf_init_data = s_d;
    wb_valid = dwv; wb_rd = drd; wb_data = ddata;
    #1;
    p_err = p_ev ? (!dwv || drd != p_erd || ddata != p_edata) : (dwv && drd != 5'd0);
    p_retire = m_retire; p_errcnt = m_err; p_mismatch = m_mismatch;
    o_ev = exp_valid; o_erd = exp_rd; o_edata = exp_data; o_err = err_pulse;
    o_retire = retire_cnt; o_errcnt = err_cnt; o_mismatch = mismatch;
    @(posedge clk);
    if (p_ev && !p_err && m_retire < 65535) m_retire++;
    if (p_err) begin
      m_mismatch = 1'b1;
      if (m_err < 65535) m_err++;
    end
    due_v[slot] = 1'b0;
    if (i_v && !s_we && i_ins[6:0] == 7'b0010011) begin
      a = (i_ins[19:15] == 5'd0) ? 32'd0 : shadow[i_ins[19:15]];
      res = ref_exec(i_ins, a);
      if (i_ins[11:7] != 5'd0) begin
        tgt = (cyc + LAT) % 64;
        due_v[tgt] = 1'b1; due_rd[tgt] = i_ins[11:7]; due_data[tgt] = res;
        shadow[i_ins[11:7]] = res;
      end
    end
    if (s_we && s_a != 5'd0) shadow[s_a] = s_d;
    cyc++;
  endtask

  task automatic idle(input int mode);
    drive(1'b0, '0, 1'b0, '0, '0, mode, 1'b0, '0, '0);
  endtask

  task automatic issue(input logic [31:0] ins, input int mode);
    drive(1'b1, ins, 1'b0, '0, '0, mode, 1'b0, '0, '0);
  endtask

  task automatic seed(input logic [4:0] a, input logic [31:0] d);
    drive(1'b0, '0, 1'b1, a, d, 0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b0; rf_init_we = 1'b0; wb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (exp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_exp_valid: got %b expected 0", exp_valid); end
    checks++; if (exp_rd !== 5'd0) begin failures++; $display("[TB] FAIL reset_exp_rd: got %0d expected 0", exp_rd); end
    checks++; if (exp_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_exp_data: got %h expected 0", exp_data); end
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_pulse: got %b expected 0", err_pulse); end
    checks++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL reset_mismatch: got %b expected 0", mismatch); end
    checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_retire_cnt: got %0d expected 0", retire_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    model_reset();
  endtask

  task automatic test_addi();
    do_reset();
    seed(5'd5, 32'h0000_0010);
    issue(itype(12'hFFF, 5'd5, 3'd0, 5'd6), 0);
    repeat (LAT) idle(0);
    checks++; if (o_ev !== 1'b1) begin failures++; $display("[TB] FAIL addi_exp_valid: got %b expected 1", o_ev); end
    checks++; if (o_erd !== 5'd6) begin failures++; $display("[TB] FAIL addi_exp_rd: got %0d expected 6", o_erd); end
    checks++; if (o_edata !== 32'h0000_000F) begin failures++; $display("[TB] FAIL addi_exp_data: got %h expected 0000000f", o_edata); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL addi_err_pulse: got %b expected 0", o_err); end
    idle(0);
    checks++; if (o_retire !== 16'd1) begin failures++; $display("[TB] FAIL addi_retire: got %0d expected 1", o_retire); end
    checks++; if (o_mismatch !== 1'b0) begin failures++; $display("[TB] FAIL addi_mismatch: got %b expected 0", o_mismatch); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(itype(12'd5, 5'd0, 3'd0, 5'd1), 0);
    issue(itype(12'd3, 5'd1, 3'd1, 5'd2), 0);
    repeat (LAT - 1) idle(0);
    checks++; if (o_ev !== 1'b1 || o_erd !== 5'd1 || o_edata !== 32'd5) begin failures++; $display("[TB] FAIL b2b_first: got v=%b rd=%0d data=%h expected v=1 rd=1 data=00000005", o_ev, o_erd, o_edata); end
    idle(0);
    checks++; if (o_ev !== 1'b1 || o_erd !== 5'd2 || o_edata !== 32'h28) begin failures++; $display("[TB] FAIL b2b_second: got v=%b rd=%0d data=%h expected v=1 rd=2 data=00000028", o_ev, o_erd, o_edata); end
    idle(0);
    checks++; if (o_retire !== 16'd2) begin failures++; $display("[TB] FAIL b2b_retire: got %0d expected 2", o_retire); end
  endtask

  task automatic test_shift_compare();
    logic [36:0] q[$];
    logic [4:0]  want_rd [4];
    logic [31:0] want_d  [4];
    want_rd = '{5'd4, 5'd4, 5'd7, 5'd8};
    want_d  = '{32'hF800_0000, 32'h0800_0000, 32'd1, 32'd1};
    do_reset();
    seed(5'd3, 32'h8000_0000);
    issue(itype(12'h404, 5'd3, 3'd5, 5'd4), 0);
    issue(itype(12'h004, 5'd3, 3'd5, 5'd4), 0);
    issue(itype(12'hFFF, 5'd0, 3'd3, 5'd7), 0);
    issue(itype(12'h000, 5'd3, 3'd2, 5'd8), 0);
    for (int i = 0; i < 2 * LAT; i++) begin
      idle(0);
      if (o_ev === 1'b1) q.push_back({o_erd, o_edata});
    end
    checks++; if (q.size() != 4) begin failures++; $display("[TB] FAIL shift_count: got %0d expected 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        checks++;
        if (q[i] !== {want_rd[i], want_d[i]}) begin failures++; $display("[TB] FAIL shift_entry%0d: got %h expected %h", i, q[i], {want_rd[i], want_d[i]}); end
      end
    end
    checks++; if (o_retire !== 16'd4 || o_errcnt !== 16'd0) begin failures++; $display("[TB] FAIL shift_counts: got retire=%0d err=%0d expected retire=4 err=0", o_retire, o_errcnt); end
  endtask

  task automatic test_errors();
    do_reset();
    seed(5'd5, 32'h0000_0010);
    issue(itype(12'hFFF, 5'd5, 3'd0, 5'd6), 1);
    repeat (LAT) idle(1);
    checks++; if (o_err !== 1'b1) begin failures++; $display("[TB] FAIL bad_data_pulse: got %b expected 1", o_err); end
    checks++; if (o_edata !== 32'h0000_000F) begin failures++; $display("[TB] FAIL bad_data_exp: got %h expected 0000000f", o_edata); end
    idle(0);
    checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL bad_data_pulse_end: got %b expected 0", o_err); end
    checks++; if (o_mismatch !== 1'b1) begin failures++; $display("[TB] FAIL bad_data_mismatch: got %b expected 1", o_mismatch); end
    checks++; if (o_errcnt !== 16'd1) begin failures++; $display("[TB] FAIL bad_data_errcnt: got %0d expected 1", o_errcnt); end
    issue(itype(12'hFFF, 5'd5, 3'd0, 5'd6), 2);
    repeat (LAT) idle(2);
    idle(0);
    checks++; if (o_errcnt !== 16'd2) begin failures++; $display("[TB] FAIL missing_errcnt: got %0d expected 2", o_errcnt); end
    checks++; if (o_mismatch !== 1'b1 || o_retire !== 16'd0) begin failures++; $display("[TB] FAIL missing_sticky: got mismatch=%b retire=%0d expected 1 0", o_mismatch, o_retire); end
  endtask

  task automatic test_spurious();
    int ev_seen;
    do_reset();
    drive(1'b0, '0, 1'b0, '0, '0, 3, 1'b1, 5'd9, 32'hDEAD);
    checks++; if (o_err !== 1'b1) begin failures++; $display("[TB] FAIL spurious_pulse: got %b expected 1", o_err); end
    drive(1'b0, '0, 1'b0, '0, '0, 3, 1'b1, 5'd0, 32'hBEEF);
    checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL x0_wb_pulse: got %b expected 0", o_err); end
    checks++; if (o_errcnt !== 16'd1) begin failures++; $display("[TB] FAIL spurious_errcnt: got %0d expected 1", o_errcnt); end
    ev_seen = 0;
    issue(itype(12'd1, 5'd1, 3'd0, 5'd0), 0);
    for (int i = 0; i < 2 * LAT; i++) begin
      idle(0);
      if (o_ev !== 1'b0) ev_seen++;
    end
    checks++; if (ev_seen != 0) begin failures++; $display("[TB] FAIL rd0_entry: got %0d entries expected 0", ev_seen); end
    checks++; if (o_errcnt !== 16'd1 || o_mismatch !== 1'b1) begin failures++; $display("[TB] FAIL rd0_counts: got err=%0d mismatch=%b expected 1 1", o_errcnt, o_mismatch); end
  endtask

  task automatic test_reset_midstream();
    int ev_seen;
    do_reset();
    seed(5'd5, 32'h0000_1234);
    drive(1'b0, '0, 1'b0, '0, '0, 3, 1'b1, 5'd9, 32'h1);
    issue(itype(12'd1, 5'd5, 3'd0, 5'd11), 0);
    issue(itype(12'd2, 5'd5, 3'd0, 5'd12), 0);
    issue(itype(12'd3, 5'd5, 3'd0, 5'd13), 0);
    repeat (LAT - 3) idle(0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    checks++; if (exp_valid !== 1'b1 || err_cnt !== 16'd1) begin failures++; $display("[TB] FAIL pre_reset_state: got v=%b err=%0d expected 1 1", exp_valid, err_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (exp_valid !== 1'b0 || exp_rd !== 5'd0 || exp_data !== 32'd0) begin failures++; $display("[TB] FAIL midreset_exp: got v=%b rd=%0d data=%h expected 0 0 0", exp_valid, exp_rd, exp_data); end
    checks++; if (retire_cnt !== 16'd0 || err_cnt !== 16'd0 || mismatch !== 1'b0 || err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL midreset_counts: got r=%0d e=%0d m=%b p=%b expected 0", retire_cnt, err_cnt, mismatch, err_pulse); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    ev_seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      idle(0);
      if (o_ev !== 1'b0) ev_seen++;
    end
    checks++; if (ev_seen != 0 || o_errcnt !== 16'd0) begin failures++; $display("[TB] FAIL flushed: got entries=%0d err=%0d expected 0 0", ev_seen, o_errcnt); end
    issue(itype(12'd0, 5'd11, 3'd0, 5'd14), 0);
    repeat (LAT) idle(0);
    checks++; if (o_ev !== 1'b1 || o_erd !== 5'd14 || o_edata !== 32'h0000_1235) begin failures++; $display("[TB] FAIL regfile_kept: got v=%b rd=%0d data=%h expected 1 14 00001235", o_ev, o_erd, o_edata); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic iv, we;
    int r, mode;
    do_reset();
    for (int k = 1; k < 8; k++) seed(5'(k), $urandom);
    for (int n = 0; n < 400; n++) begin
      ins = itype(12'($urandom), 5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 6) == 0) ins[6:0] = 7'b0110011;
      iv = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 19);
      mode = (r < 17) ? 0 : r - 16;
      drive(iv, ins, we, 5'($urandom_range(0, 7)), $urandom, mode,
            1'b1, 5'($urandom_range(0, 31)), $urandom);
      checks++; if (o_ev !== p_ev) begin failures++; $display("[TB] FAIL rand_exp_valid: cycle %0d got %b expected %b", n, o_ev, p_ev); end
      if (p_ev) begin
        checks++; if (o_erd !== p_erd || o_edata !== p_edata) begin failures++; $display("[TB] FAIL rand_exp_entry: cycle %0d got %0d/%h expected %0d/%h", n, o_erd, o_edata, p_erd, p_edata); end
      end
      checks++; if (o_err !== p_err) begin failures++; $display("[TB] FAIL rand_err_pulse: cycle %0d got %b expected %b", n, o_err, p_err); end
      checks++; if (o_retire !== 16'(p_retire) || o_errcnt !== 16'(p_errcnt)) begin failures++; $display("[TB] FAIL rand_counters: cycle %0d got %0d/%0d expected %0d/%0d", n, o_retire, o_errcnt, p_retire, p_errcnt); end
      checks++; if (o_mismatch !== p_mismatch) begin failures++; $display("[TB] FAIL rand_mismatch: cycle %0d got %b expected %b", n, o_mismatch, p_mismatch); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_shift_compare();
    test_errors();
    test_spurious();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ialu_shadow_checker.md
# ialu_shadow_checker

Golden-model checker that sits beside the Sodor 5-stage core in the verification harness. It consumes the same I-type ALU instruction stream the bench drives into the core and executes each instruction architecturally against a shadow register file. It delays each expected writeback by the core's pipeline latency and compares it against the core's writeback port. It raises sticky and pulsed mismatch flags and keeps retire and error counters.

## Interface
- WORD_SIZE, 32, data width
- NUM_REGS, 32, shadow register count (x0 hardwired zero)
- LATENCY, 4, cycles from instruction accept to expected core writeback; legal range 1..8
- CNT_W, 16, counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears pipeline, flags, counters
- instr_valid  in  1  instr is presented this cycle
- instr  in  32  RISC-V instruction word
- rf_init_we  in  1  seed write to shadow regfile
- rf_init_addr  in  5  seed register index
- rf_init_data  in  WORD_SIZE  seed value
- wb_valid  in  1  core register-file write this cycle
- wb_rd  in  5  core write index
- wb_data  in  WORD_SIZE  core write value
- exp_valid  out  1  expected writeback due this cycle
- exp_rd  out  5  expected index
- exp_data  out  WORD_SIZE  expected value
- err_pulse  out  1  one-cycle error strobe
- mismatch  out  1  sticky error flag
- retire_cnt  out  CNT_W  matched writebacks
- err_cnt  out  CNT_W  errors

## Operation
- Accept: instr_valid=1 and rf_init_we=0. Accepted word with opcode 7'b0010011 is executed; any other opcode is a bubble (no expected entry).
- Fields: rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15], imm=sign-extended instr[31:20]; rs1 value read from shadow regfile (x0 reads 0).
- funct3: 0 ADDI (wrap mod 2^32); 2 SLTI signed compare, result 0/1; 3 SLTIU unsigned compare against sign-extended imm; 4 XORI; 6 ORI; 7 ANDI; 1 SLLI by instr[24:20]; 5 SRAI if instr[30]=1 else SRLI, shamt instr[24:20].
- Shadow regfile updated at the same edge as accept (architectural, in-order), so back-to-back dependent instructions see prior results; writes to x0 discarded.
- Expected entry {rd, result} enters a LATENCY-deep shift pipeline only when rd≠0; rd=0 instructions produce no entry.
- Seed: rf_init_we writes rf_init_data to rf_init_addr (x0 ignored). Same-cycle instr_valid is dropped as a bubble.
- Compare at pipeline tail each cycle:
  - exp_valid & wb_valid & rd and data equal → retire_cnt+1.
  - exp_valid & wb_valid & any field differs → error.
  - exp_valid & !wb_valid → error (missing).
  - !exp_valid & wb_valid & wb_rd≠0 → error (spurious). wb_rd=0 writes are ignored.
- Error: err_pulse=1 that cycle, mismatch set and held until reset, err_cnt+1.
- Counters saturate at all-ones.

## Timing
- Reset values: exp_valid=0, exp_rd=0, exp_data=0, err_pulse=0, mismatch=0, retire_cnt=0, err_cnt=0. Pipeline valids are cleared. Shadow regfile contents are not reset; they are preserved and re-seeded by the bench.
- Instruction accepted at edge N appears on exp_* during cycle N+LATENCY. exp_* are registered outputs.
- Comparison is combinational on exp_* and wb_*. err_pulse is combinational in the same cycle. Counters and mismatch update at the following edge.
- Reset asserted mid-stream: in-flight entries are discarded immediately (asynchronous); no errors are reported for them.
- Throughput: one instruction per cycle, no backpressure.

## Test plan
- Seed x5=0x00000010, issue ADDI x6,x5,-1 (imm 0xFFF); drive wb x6=0x0000000F at +LATENCY → retire_cnt=1, mismatch=0.
- Back-to-back ADDI x1,x0,5 then SLLI x2,x1,3 → expected x1=5 then x2=0x28 on consecutive cycles; matching wb → retire_cnt=2.
- Seed x3=0x80000000: SRAI x4,x3,4 → 0xF8000000; SRLI x4,x3,4 → 0x08000000; SLTIU x7,x0,-1 → 1; SLTI x8,x3,0 → 1.
- Expected x6=0x0F but wb_data=0x0E → err_pulse one cycle, mismatch=1 and stays 1, err_cnt=1. Omit wb entirely → err_cnt=2.
- wb_valid with wb_rd=9 and no expected entry → error; wb_rd=0 with no expected entry → no error. ADDI x0,x1,1 → no expected entry.
- Issue 3 instructions, assert reset before they retire → exp_valid=0 and counters 0 immediately; shadow regfile retains prior values.
